// File: rtl/gpr_csr_file.sv
// Integer register file plus machine-mode CSR unit.
// Two combinational read ports with optional write-to-read bypass, one write
// port, CSR read-modify-write, trap entry/mret and the mcycle/minstret counters.
module gpr_csr_file #(
   parameter int          XLEN        = 64,
   parameter int          NREGS       = 32,
   parameter bit          BYPASS      = 1'b1,
   parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [$clog2(NREGS)-1:0]  rs1_addr,
   input  logic [$clog2(NREGS)-1:0]  rs2_addr,
   output logic [XLEN-1:0]           rs1_rdata,
   output logic [XLEN-1:0]           rs2_rdata,
   input  logic [$clog2(NREGS)-1:0]  rd_addr,
   input  logic [XLEN-1:0]           rd_wdata,
   input  logic                      reg_wen,
   input  logic [11:0]               csr_addr,
   input  logic [1:0]                csr_op,
   input  logic [XLEN-1:0]           csr_src,
   output logic [XLEN-1:0]           csr_rdata,
   output logic                      csr_illegal,
   input  logic                      trap_valid,
   input  logic [XLEN-1:0]           trap_pc,
   input  logic [XLEN-1:0]           trap_cause,
   input  logic                      mret_valid,
   input  logic                      instr_retire,
   output logic [XLEN-1:0]           trap_vector,
   output logic [XLEN-1:0]           epc
);

   localparam int AW = $clog2(NREGS);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;

   localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] ALIGN4    = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] MTVEC_RST = MTVEC_RESET[XLEN-1:0];

   // Read-modify-write combine for the three CSR instruction flavours.
   function automatic logic [XLEN-1:0] csr_apply(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] src);
      case (op)
         2'b01:   csr_apply = src;
         2'b10:   csr_apply = old_v | src;
         2'b11:   csr_apply = old_v & ~src;
         default: csr_apply = old_v;
      endcase
   endfunction

   logic [XLEN-1:0] regs [NREGS];

   logic            mie_q;
   logic            mpie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [XLEN-1:0] mcycle_q;
   logic [XLEN-1:0] minstret_q;

   logic [XLEN-1:0] mstatus_rd;
   logic [XLEN-1:0] csr_old;
   logic [XLEN-1:0] csr_new;
   logic            csr_hit;
   logic            csr_wen;

   // GPR storage; x0 is never written so it stays zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (reg_wen && (rd_addr != '0)) begin
         regs[rd_addr] <= rd_wdata;
      end
   end

   // Read ports: x0 is hardwired, and a same-cycle write can be forwarded.
   always_comb begin
      rs1_rdata = '0;
      rs2_rdata = '0;
      if (rs1_addr != '0) begin
         if (BYPASS && reg_wen && (rd_addr == rs1_addr)) rs1_rdata = rd_wdata;
         else                                             rs1_rdata = regs[rs1_addr];
      end
      if (rs2_addr != '0) begin
         if (BYPASS && reg_wen && (rd_addr == rs2_addr)) rs2_rdata = rd_wdata;
         else                                             rs2_rdata = regs[rs2_addr];
      end
   end

   // Assemble mstatus from its stored fields; MPP is fixed at machine mode.
   always_comb begin
      mstatus_rd        = '0;
      mstatus_rd[12:11] = 2'b11;
      mstatus_rd[7]     = mpie_q;
      mstatus_rd[3]     = mie_q;
   end

   // CSR address decode, old value, new value and write qualification.
   always_comb begin
      csr_hit = 1'b1;
      csr_old = '0;
      case (csr_addr)
         A_MSTATUS:  csr_old = mstatus_rd;
         A_MTVEC:    csr_old = mtvec_q;
         A_MSCRATCH: csr_old = mscratch_q;
         A_MEPC:     csr_old = mepc_q;
         A_MCAUSE:   csr_old = mcause_q;
         A_MCYCLE:   csr_old = mcycle_q;
         A_MINSTRET: csr_old = minstret_q;
         default:    csr_hit = 1'b0;
      endcase
      csr_new     = csr_apply(csr_op, csr_old, csr_src);
      csr_illegal = (csr_op != 2'b00) && !csr_hit;
      // Trap and mret both outrank an instruction's CSR write.
      csr_wen     = (csr_op != 2'b00) && csr_hit && !trap_valid && !mret_valid;
   end

   assign csr_rdata   = csr_old;
   assign trap_vector = mtvec_q & ALIGN4;
   assign epc         = mepc_q;

   // Trap entry, mret and CSR-instruction writes, in that priority order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else if (trap_valid) begin
         mepc_q   <= trap_pc & ALIGN4;
         mcause_q <= trap_cause;
         mpie_q   <= mie_q;
         mie_q    <= 1'b0;
      end else if (mret_valid) begin
         mie_q  <= mpie_q;
         mpie_q <= 1'b1;
      end else if (csr_wen) begin
         case (csr_addr)
            A_MSTATUS: begin
               mie_q  <= csr_new[3];
               mpie_q <= csr_new[7];
            end
            A_MTVEC:    mtvec_q    <= csr_new;
            A_MSCRATCH: mscratch_q <= csr_new;
            A_MEPC:     mepc_q     <= csr_new & ALIGN4;
            A_MCAUSE:   mcause_q   <= csr_new;
            default: ;
         endcase
      end
   end

   // Free-running counters; an explicit CSR write replaces that cycle's increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (csr_wen && (csr_addr == A_MCYCLE)) mcycle_q <= csr_new;
         else                                   mcycle_q <= mcycle_q + ONE;
         if (csr_wen && (csr_addr == A_MINSTRET)) minstret_q <= csr_new;
         else if (instr_retire)                   minstret_q <= minstret_q + ONE;
      end
   end

endmodule
